// File: rtl/qpsk_pkg.sv
// Shared types and elaboration-time helpers for the QPSK/BPSK modulator.
// The sine helper builds the carrier table from integer arithmetic, so the table needs no image file.
package qpsk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Peak ROM amplitude for a signed sample of width dw.
    function automatic int amp(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Bhaskara rational sine over one period of sps points, scaled to a.
    // It is exact at 0/90/180/270 degrees and never exceeds a, so the sum cannot overflow.
    function automatic int sin_q(input int k, input int sps, input int a);
        int     h;
        int     x;
        bit     neg;
        longint num;
        longint den;
        int     v;
        h   = sps / 2;
        x   = k % sps;
        neg = 1'b0;
        if (x >= h) begin
            x   = x - h;
            neg = 1'b1;
        end
        num = longint'(16) * longint'(x) * longint'(h - x) * longint'(a);
        den = longint'(5) * longint'(h) * longint'(h) - longint'(4) * longint'(x) * longint'(h - x);
        v   = int'((longint'(2) * num + den) / (longint'(2) * den));
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/sincos_rom.sv
// Carrier lookup: registered synchronous read of {cos,sin}, addressed by phase, gated by en.
// ROM_FILE is kept as the image name for drop-in compatibility; the table is generated at elaboration.
module sincos_rom
    import qpsk_pkg::*;
#(
    parameter int    DW       = 8,
    parameter int    SPS      = 16,
    parameter string ROM_FILE = "sincos.mem",
    localparam int   AW       = clog2(SPS)
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic [AW-1:0]       addr_i,
    output logic [2*DW-1:0]     data_o
);

    localparam int A = amp(DW);

    logic [2*DW-1:0] rom_w [SPS];
    logic [2*DW-1:0] data_q;

    for (genvar k = 0; k < SPS; k++) begin : g_tbl
        localparam int S = sin_q(k, SPS, A);
        localparam int C = sin_q(k + SPS / 4, SPS, A);
        assign rom_w[k] = {DW'(C), DW'(S)};
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_q <= rom_w[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/qpsk_mod_param.sv
// Parametrised QPSK/BPSK modulator: serial bits in, one carrier cycle per symbol out.
// Pipeline: phase/symbol select -> registered ROM read -> registered signed sum.
module qpsk_mod_param
    import qpsk_pkg::*;
#(
    parameter int    DW       = 8,
    parameter int    SPS      = 16,
    parameter string ROM_FILE = "sincos.mem"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic                 bpsk_mode,
    output logic signed [DW:0]   sample_out,
    output logic                 sample_valid,
    output logic                 symbol_start,
    output logic                 underrun
);

    // Handshake: a bit transfers on a rising clk edge where bit_valid && bit_ready;
    // bit_ready depends only on registered state, never on bit_valid.

    localparam int              AW      = clog2(SPS);
    localparam logic [AW-1:0]   PH_LAST = AW'(SPS - 1);

    logic [AW-1:0]   phase_q;
    state_e          state_q, state_d;
    logic            ready_q;
    logic            pend_full_q, pend_full_d;
    logic            pend_eve_q, pend_eve_d;
    logic            pend_odd_q, pend_odd_d;
    logic            pend_bpsk_q, pend_bpsk_d;
    logic            col_have_q, col_have_d;
    logic            col_eve_q, col_eve_d;
    logic            sym_eve_q, sym_eve_d;
    logic            sym_odd_q, sym_odd_d;
    logic            sym_bpsk_q, sym_bpsk_d;
    logic            underrun_now;
    logic            accept;
    logic            boundary;

    assign accept   = bit_valid && ready_q;
    assign boundary = en && (phase_q == PH_LAST);

    always_comb begin
        state_d      = state_q;
        pend_full_d  = pend_full_q;
        pend_eve_d   = pend_eve_q;
        pend_odd_d   = pend_odd_q;
        pend_bpsk_d  = pend_bpsk_q;
        col_have_d   = col_have_q;
        col_eve_d    = col_eve_q;
        sym_eve_d    = sym_eve_q;
        sym_odd_d    = sym_odd_q;
        sym_bpsk_d   = sym_bpsk_q;
        underrun_now = 1'b0;

        if (boundary) begin
            if (pend_full_q) begin
                sym_eve_d   = pend_eve_q;
                sym_odd_d   = pend_odd_q;
                sym_bpsk_d  = pend_bpsk_q;
                pend_full_d = 1'b0;
                state_d     = ST_RUN;
            end else if (state_q == ST_RUN) begin
                state_d      = ST_IDLE;
                underrun_now = 1'b1;
            end
        end

        // ready_q is low whenever pending is full, so intake never collides with a transfer.
        if (accept) begin
            if (!col_have_q) begin
                if (bpsk_mode) begin
                    pend_eve_d  = bit_in;
                    pend_odd_d  = 1'b0;
                    pend_bpsk_d = 1'b1;
                    pend_full_d = 1'b1;
                end else begin
                    col_have_d = 1'b1;
                    col_eve_d  = bit_in;
                end
            end else begin
                pend_eve_d  = col_eve_q;
                pend_odd_d  = bit_in;
                pend_bpsk_d = 1'b0;
                pend_full_d = 1'b1;
                col_have_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            ready_q     <= 1'b0;
            pend_full_q <= 1'b0;
            pend_eve_q  <= 1'b0;
            pend_odd_q  <= 1'b0;
            pend_bpsk_q <= 1'b0;
            col_have_q  <= 1'b0;
            col_eve_q   <= 1'b0;
            sym_eve_q   <= 1'b0;
            sym_odd_q   <= 1'b0;
            sym_bpsk_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= !pend_full_d;
            pend_full_q <= pend_full_d;
            pend_eve_q  <= pend_eve_d;
            pend_odd_q  <= pend_odd_d;
            pend_bpsk_q <= pend_bpsk_d;
            col_have_q  <= col_have_d;
            col_eve_q   <= col_eve_d;
            sym_eve_q   <= sym_eve_d;
            sym_odd_q   <= sym_odd_d;
            sym_bpsk_q  <= sym_bpsk_d;
            if (en) begin
                phase_q <= phase_q + AW'(1);
            end
        end
    end

    logic [2*DW-1:0] rom_data;

    sincos_rom #(
        .DW       (DW),
        .SPS      (SPS),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk_i  (clk),
        .en_i   (en),
        .addr_i (phase_q),
        .data_o (rom_data)
    );

    // Stage 1 carries the symbol context that travels alongside the ROM read.
    logic s1_valid_q, s1_run_q, s1_eve_q, s1_odd_q, s1_bpsk_q, s1_sos_q, s1_ur_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_run_q   <= 1'b0;
            s1_eve_q   <= 1'b0;
            s1_odd_q   <= 1'b0;
            s1_bpsk_q  <= 1'b0;
            s1_sos_q   <= 1'b0;
            s1_ur_q    <= 1'b0;
        end else begin
            s1_valid_q <= en;
            if (en) begin
                s1_run_q  <= (state_q == ST_RUN);
                s1_eve_q  <= sym_eve_q;
                s1_odd_q  <= sym_odd_q;
                s1_bpsk_q <= sym_bpsk_q;
                s1_sos_q  <= (state_q == ST_RUN) && (phase_q == '0);
                s1_ur_q   <= underrun_now;
            end
        end
    end

    logic signed [DW-1:0] rom_cos, rom_sin;
    logic signed [DW:0]   cos_x, sin_x, i_term, q_term, sum_d;

    assign rom_cos = rom_data[2*DW-1:DW];
    assign rom_sin = rom_data[DW-1:0];

    always_comb begin
        cos_x  = (DW+1)'(rom_cos);
        sin_x  = (DW+1)'(rom_sin);
        i_term = s1_eve_q ? cos_x : -cos_x;
        q_term = '0;
        if (!s1_bpsk_q) begin
            q_term = s1_odd_q ? sin_x : -sin_x;
        end
        sum_d = s1_run_q ? (i_term + q_term) : '0;
    end

    logic signed [DW:0] sample_q;
    logic               valid_q, sos_q, ur_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            sos_q    <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            sos_q   <= s1_valid_q && s1_sos_q;
            ur_q    <= s1_valid_q && s1_ur_q;
            if (s1_valid_q) begin
                sample_q <= sum_d;
            end
        end
    end

    assign bit_ready    = ready_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign symbol_start = sos_q;
    assign underrun     = ur_q;

endmodule

// File: tb/tb_qpsk_mod_param.sv
// Directed bench for qpsk_mod_param at DW=8, SPS=4 (cos=[127,0,-127,0], sin=[0,127,0,-127]).
module tb_qpsk_mod_param;

  localparam int DW  = 8;
  localparam int SPS = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic bpsk_mode = 1'b0;
  logic bit_ready;
  logic signed [DW:0] sample_out;
  logic sample_valid;
  logic symbol_start;
  logic underrun;

  int checks = 0;
  int errors = 0;

  int cos_t[SPS] = '{127, 0, -127, 0};
  int sin_t[SPS] = '{0, 127, 0, -127};

  logic [DW:0] exp_q[$];
  logic [DW:0] rec_s[$];
  bit          rec_v[$];
  bit          rec_sos[$];
  bit          rec_ur[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  qpsk_mod_param #(
    .DW       (DW),
    .SPS      (SPS),
    .ROM_FILE ("sincos.mem")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .bpsk_mode    (bpsk_mode),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .symbol_start (symbol_start),
    .underrun     (underrun)
  );

  // per-cycle monitor
  always @(negedge clk) begin
    rec_v.push_back(sample_valid);
    rec_s.push_back(sample_out);
    rec_sos.push_back(symbol_start);
    rec_ur.push_back(underrun);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
  endtask

  task automatic send_bit(input logic b, output bit rdy_after);
    bit rdy;
    int n;
    n = 0;
    bit_valid = 1'b1;
    bit_in = b;
    forever begin
      rdy = bit_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 100) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    rdy_after = bit_ready;
  endtask

  task automatic send_pair(input logic e, input logic o);
    bit ra;
    send_bit(e, ra);
    send_bit(o, ra);
  endtask

  task automatic push_sym(input bit e, input bit o, input bit bp);
    int v;
    for (int p = 0; p < SPS; p++) begin
      v = (e ? cos_t[p] : -cos_t[p]) + (bp ? 0 : (o ? sin_t[p] : -sin_t[p]));
      exp_q.push_back((DW+1)'(v));
    end
  endtask

  // scoreboard: find the first symbol_start at or after 'from' and compare nsym symbols
  task automatic analyze(input string tag, input int from, input int nsym, output int sos_idx);
    int n;
    int nz;
    int nur;
    logic [DW:0] e;
    n = nsym * SPS;
    sos_idx = -1;
    for (int i = from; i < rec_v.size(); i++) begin
      if (rec_v[i] && rec_sos[i]) begin
        sos_idx = i;
        break;
      end
    end
    check({tag, "_sos_found"}, int'(sos_idx >= 0 && sos_idx + n <= rec_v.size()), 1);
    if (sos_idx < 0 || sos_idx + n > rec_v.size()) begin
      exp_q.delete();
      return;
    end
    nz = 0;
    for (int j = from; j < sos_idx; j++) begin
      if (rec_v[j] && rec_s[j] != '0) nz++;
    end
    check({tag, "_idle_zero"}, nz, 0);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_sample%0d", tag, k), int'($signed(rec_s[sos_idx + k])), int'($signed(e)));
      check($sformatf("%s_valid%0d", tag, k), int'(rec_v[sos_idx + k]), 1);
      check($sformatf("%s_sos%0d", tag, k), int'(rec_sos[sos_idx + k]), int'(k % SPS == 0));
    end
    nur = 0;
    for (int j = sos_idx; j <= sos_idx + n - 2; j++) begin
      if (rec_ur[j]) nur++;
    end
    check({tag, "_no_underrun"}, nur, 0);
  endtask

  function automatic int count_ur(input int a, input int b);
    int c;
    c = 0;
    for (int j = a; j <= b && j < rec_ur.size(); j++) begin
      if (rec_ur[j]) c++;
    end
    return c;
  endfunction

  function automatic int count_bad_idle(input int a, input int b);
    int c;
    c = 0;
    for (int j = a; j <= b && j < rec_v.size(); j++) begin
      if (!rec_v[j] || rec_s[j] != '0 || rec_sos[j]) c++;
    end
    return c;
  endfunction

  initial begin
    int from, mark, idx, idx2, n;
    bit ra;
    logic [7:0] pat;

    // reset state, before any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_sample", int'(sample_out), 0);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_ready", int'(bit_ready), 0);
    check("reset_sos", int'(symbol_start), 0);
    check("reset_underrun", int'(underrun), 0);

    // 1: QPSK pair 1,0
    do_reset();
    from = rec_v.size();
    send_pair(1'b1, 1'b0);
    bit_valid = 1'b0;
    repeat (20) @(negedge clk);
    push_sym(1, 0, 0);
    analyze("t1", from, 1, idx);

    // 2: back-to-back pairs 1,1 then 0,0
    do_reset();
    from = rec_v.size();
    send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b0);
    bit_valid = 1'b0;
    repeat (24) @(negedge clk);
    push_sym(1, 1, 0);
    push_sym(0, 0, 0);
    analyze("t2", from, 2, idx);

    // 3: stall after one pair, then restart
    do_reset();
    from = rec_v.size();
    send_pair(1'b1, 1'b0);
    bit_valid = 1'b0;
    repeat (20) @(negedge clk);
    push_sym(1, 0, 0);
    analyze("t3a", from, 1, idx);
    check("t3_underrun_once", count_ur(from, rec_ur.size() - 1), 1);
    check("t3_idle_valid_zero", count_bad_idle(idx + SPS, rec_v.size() - 1), 0);
    mark = rec_v.size();
    send_pair(1'b0, 1'b1);
    bit_valid = 1'b0;
    repeat (20) @(negedge clk);
    push_sym(0, 1, 0);
    analyze("t3b", mark, 1, idx2);
    if (idx2 >= 0) begin
      check("t3_restart_underrun", count_ur(mark, idx2 + SPS - 2), 0);
      check("t3_boundary_aligned", (idx2 - idx) % SPS, 0);
    end

    // 4: BPSK bits 1,0
    do_reset();
    bpsk_mode = 1'b1;
    from = rec_v.size();
    send_bit(1'b1, ra);
    check("t4_ready_after_bpsk", int'(ra), 0);
    send_bit(1'b0, ra);
    bit_valid = 1'b0;
    repeat (24) @(negedge clk);
    bpsk_mode = 1'b0;
    push_sym(1, 0, 1);
    push_sym(0, 0, 1);
    analyze("t4", from, 2, idx);

    // 5: continuous bit_valid, ready profile and no lost/duplicated bits
    do_reset();
    from = rec_v.size();
    pat = 8'b0011_1001;
    for (int k = 0; k < 8; k++) begin
      send_bit(pat[k], ra);
      check($sformatf("t5_ready_after%0d", k), int'(ra), int'(k % 2 == 0));
    end
    bit_valid = 1'b0;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 8; k += 2) begin
      push_sym(pat[k], pat[k + 1], 0);
    end
    analyze("t5", from, 4, idx);

    // 6: reset mid-symbol with a pair pending
    do_reset();
    send_pair(1'b1, 1'b0);
    send_pair(1'b1, 1'b1);
    bit_valid = 1'b0;
    n = 0;
    while (!(sample_valid && symbol_start) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_sos_seen", int'(sample_valid && symbol_start), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_sample", int'(sample_out), 0);
    check("t6_rst_valid", int'(sample_valid), 0);
    check("t6_rst_ready", int'(bit_ready), 0);
    check("t6_rst_sos", int'(symbol_start), 0);
    check("t6_rst_underrun", int'(underrun), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mark = rec_v.size();
    repeat (20) @(negedge clk);
    check("t6_idle_after_reset", count_bad_idle(mark + 3, rec_v.size() - 1), 0);
    check("t6_no_underrun", count_ur(mark, rec_ur.size() - 1), 0);
    from = rec_v.size();
    send_pair(1'b0, 1'b1);
    bit_valid = 1'b0;
    repeat (20) @(negedge clk);
    push_sym(0, 1, 0);
    analyze("t6b", from, 1, idx);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
